// File: rtl/game_pkg.sv
// Shared types and helpers for the symbol-memory game sequencer.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        SHOW,
        INPUT,
        PASS,
        END
    } state_t;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] DEF_SEED  = 16'hACE1;

    function automatic logic [5:0] len(input logic [3:0] level, input int base);
        return 6'(level) + 6'(base) - 6'd1;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sym_lfsr.sv
// 16-bit right-shifting Galois LFSR; the single pattern source of the game.
module sym_lfsr
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = DEF_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] loadVal,
    input  logic        step,
    output logic [15:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= loadVal;
        end else if (step) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Level sequencer: countdown handshake, pattern display and entry checking.
// Optional COUNT watchdog on Tick1Hz is enabled by defining SEQ_TIMEOUT_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int          SYM_W         = 2,
    parameter int          MAX_LEVEL     = 9,
    parameter int          BASE_LEN      = 3,
    parameter logic [15:0] SEED          = DEF_SEED,
    parameter int          TIMEOUT_TICKS = 10
) (
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             Tick1Hz,
    input  logic             playBtn,
    input  logic             symValid,
    input  logic [SYM_W-1:0] symIn,
    input  logic             doneCounting,
    output logic             start,
    output logic [3:0]       curLevel,
    output logic             showValid,
    output logic [SYM_W-1:0] showSym,
    output logic             busy,
    output logic             win,
    output logic             gameOver,
    output logic             timeoutErr
);

    state_t          state;
    logic [15:0]     lfsr;
    logic [15:0]     levelSeed;
    logic [5:0]      idx;
    logic [5:0]      cur_len;
    logic [SYM_W-1:0] cur_sym;
    logic            sym_ok;
    logic            lfsr_load;
    logic            lfsr_step;

`ifdef SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    logic [TW-1:0] tcnt;
`else
    assign timeoutErr = 1'b0;
`endif

    assign cur_len = len(curLevel, BASE_LEN);
    assign cur_sym = lfsr[SYM_W-1:0];
    assign sym_ok  = (symIn == cur_sym);
    assign busy    = (state != IDLE) && (state != END);

    // Free-running in IDLE/END for entropy; rewound to levelSeed per phase.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        unique case (state)
            IDLE, END: lfsr_step = 1'b1;
            COUNT:     lfsr_load = doneCounting;
            SHOW: begin
                if (Tick1Hz) begin
                    if (idx < cur_len) lfsr_step = 1'b1;
                    else               lfsr_load = 1'b1;
                end
            end
            INPUT:     lfsr_step = symValid && sym_ok;
            default: ;
        endcase
    end

    sym_lfsr #(
        .SEED(SEED)
    ) u_lfsr (
        .clk    (Clk100M),
        .rst_n  (Rst_n),
        .load   (lfsr_load),
        .loadVal(levelSeed),
        .step   (lfsr_step),
        .q      (lfsr)
    );

    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= IDLE;
            levelSeed <= SEED;
            idx       <= '0;
            start     <= 1'b0;
            curLevel  <= 4'd1;
            showValid <= 1'b0;
            showSym   <= '0;
            win       <= 1'b0;
            gameOver  <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            tcnt       <= '0;
            timeoutErr <= 1'b0;
`endif
        end else begin
            start <= 1'b0;
            unique case (state)
                IDLE, END: begin
                    if (playBtn) begin
                        levelSeed <= lfsr;
                        curLevel  <= 4'd1;
                        win       <= 1'b0;
                        gameOver  <= 1'b0;
                        start     <= 1'b1;
                        state     <= COUNT;
`ifdef SEQ_TIMEOUT_EN
                        tcnt       <= '0;
                        timeoutErr <= 1'b0;
`endif
                    end
                end
                COUNT: begin
                    if (doneCounting) begin
                        idx   <= '0;
                        state <= SHOW;
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (Tick1Hz) begin
                        if (tcnt == TW'(TIMEOUT_TICKS - 1)) begin
                            gameOver   <= 1'b1;
                            timeoutErr <= 1'b1;
                            state      <= END;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
`endif
                end
                SHOW: begin
                    if (Tick1Hz) begin
                        if (idx < cur_len) begin
                            showValid <= 1'b1;
                            showSym   <= cur_sym;
                            idx       <= idx + 6'd1;
                        end else begin
                            showValid <= 1'b0;
                            idx       <= '0;
                            state     <= INPUT;
                        end
                    end
                end
                INPUT: begin
                    if (symValid) begin
                        if (!sym_ok) begin
                            gameOver <= 1'b1;
                            state    <= END;
                        end else begin
                            idx <= idx + 6'd1;
                            if (idx == cur_len - 6'd1) state <= PASS;
                        end
                    end
                end
                PASS: begin
                    // lfsr now sits on the symbol after the pattern
                    levelSeed <= lfsr;
                    if (curLevel == 4'(MAX_LEVEL)) begin
                        win   <= 1'b1;
                        state <= END;
                    end else begin
                        curLevel <= curLevel + 4'd1;
                        start    <= 1'b1;
                        state    <= COUNT;
`ifdef SEQ_TIMEOUT_EN
                        tcnt <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized scoreboard bench for game_sequencer against a pattern-level model.
module tb_game_sequencer;

    localparam int          MAXL  = 2;
    localparam int          BASE  = 3;
    localparam logic [15:0] SEEDV = 16'hACE1;
    localparam int EV_S = 0;
    localparam int EV_Y = 1;
    localparam int EV_E = 2;

    logic       Clk100M = 1'b0;
    logic       Rst_n = 1'b0;
    logic       Tick1Hz = 1'b0;
    logic       playBtn = 1'b0;
    logic       symValid = 1'b0;
    logic [1:0] symIn = 2'd0;
    logic       doneCounting = 1'b0;
    logic       start;
    logic [3:0] curLevel;
    logic       showValid;
    logic [1:0] showSym;
    logic       busy;
    logic       win;
    logic       gameOver;
    logic       timeoutErr;

    game_sequencer #(
        .SYM_W(2), .MAX_LEVEL(MAXL), .BASE_LEN(BASE),
        .SEED(SEEDV), .TIMEOUT_TICKS(10)
    ) dut (
        .Clk100M(Clk100M), .Rst_n(Rst_n), .Tick1Hz(Tick1Hz),
        .playBtn(playBtn), .symValid(symValid), .symIn(symIn),
        .doneCounting(doneCounting), .start(start), .curLevel(curLevel),
        .showValid(showValid), .showSym(showSym), .busy(busy),
        .win(win), .gameOver(gameOver), .timeoutErr(timeoutErr)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        int kind;
        int data;
    } ev_t;

    ev_t         q[$];
    int          nvec = 0;
    int          nerr = 0;
    int          cyc = 0;
    logic        tick_q = 1'b0;
    logic        busy_q = 1'b0;
    logic [15:0] free_val;
    int          free_c;

    always @(posedge Clk100M) begin
        cyc    <= cyc + 1;
        tick_q <= Tick1Hz;
    end

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [15:0] adv(input logic [15:0] l, input int n);
        for (int i = 0; i < n; i++) l = nxt(l);
        return l;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic mon(input int kind, input logic [31:0] act, input string name);
        ev_t e;
        if (q.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL %s unexpected: got %0d want none", name, act);
            return;
        end
        e = q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        chk(name, act, e.data);
    endtask

    always @(negedge Clk100M) begin
        if (!Rst_n) begin
            busy_q = 1'b0;
        end else begin
            if (start) mon(EV_S, 32'(curLevel), "start");
            if (showValid && tick_q) mon(EV_Y, 32'(showSym), "sym");
            if (busy_q && !busy)
                mon(EV_E, 32'({win, gameOver, timeoutErr, curLevel}), "end");
            busy_q = busy;
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic do_reset();
        #1 Rst_n = 1'b0;
        Tick1Hz = 0; playBtn = 0; symValid = 0; doneCounting = 0;
        nclk(2);
        chk("rst_start", start, 0);
        chk("rst_level", curLevel, 1);
        chk("rst_showValid", showValid, 0);
        chk("rst_showSym", showSym, 0);
        chk("rst_busy", busy, 0);
        chk("rst_win", win, 0);
        chk("rst_gameOver", gameOver, 0);
        chk("rst_timeoutErr", timeoutErr, 0);
        #1 Rst_n = 1'b1;
        free_val = SEEDV;
        free_c   = cyc;
    endtask

    task automatic tick1();
        Tick1Hz = 1;
        nclk(1);
        Tick1Hz = 0;
    endtask

    // wl/wi: level and entry to get wrong (wl=0: none); inj: ignored-input noise
    task automatic play(input int wl, input int wi, input bit inj, input bit race);
        logic [15:0] v;
        logic [15:0] lseed;
        logic [1:0]  pat[$];
        logic [1:0]  s;
        int          L;
        int          cs;
        bit          bad;
        v = adv(free_val, cyc - free_c);
        playBtn = 1;
        q.push_back('{EV_S, 1});
        nclk(1);
        playBtn = 0;
        chk("start_clears", {win, gameOver, timeoutErr}, 0);
        for (int lvl = 1; lvl <= MAXL; lvl++) begin
            L = lvl + BASE - 1;
            if (race) begin
                for (int k = 0; k < 9; k++) begin
                    tick1();
                    nclk(1);
                end
                Tick1Hz = 1;
            end else begin
                nclk($urandom_range(0, 3));
            end
            doneCounting = 1;
            nclk(1);
            doneCounting = 0;
            Tick1Hz = 0;
            lseed = v;
            pat.delete();
            for (int i = 0; i < L; i++) begin
                pat.push_back(v[1:0]);
                q.push_back('{EV_Y, int'(v[1:0])});
                v = nxt(v);
            end
            for (int t = 0; t <= L; t++) begin
                if (inj && t == 1) begin
                    symValid = 1;
                    symIn = ~pat[0];
                    nclk(1);
                    symValid = 0;
                end
                nclk($urandom_range(1, 3));
                Tick1Hz = 1;
                if (inj && t == L) begin
                    symValid = 1;
                    symIn = ~pat[0];
                end
                nclk(1);
                Tick1Hz = 0;
                symValid = 0;
            end
            if (inj) begin
                doneCounting = 1;
                nclk(1);
                doneCounting = 0;
            end
            for (int i = 0; i < L; i++) begin
                nclk($urandom_range(0, 2));
                bad = (lvl == wl) && (i == wi);
                s = pat[i];
                if (bad) s = s ^ 2'($urandom_range(1, 3));
                if (bad)
                    q.push_back('{EV_E, int'({1'b0, 1'b1, 1'b0, 4'(lvl)})});
                else if (i == L - 1 && lvl == MAXL)
                    q.push_back('{EV_E, int'({1'b1, 1'b0, 1'b0, 4'(lvl)})});
                symValid = 1;
                symIn = s;
                cs = cyc;
                nclk(1);
                symValid = 0;
                if (bad) begin
                    chk("loss_gameOver", gameOver, 1);
                    chk("loss_busy", busy, 0);
                    chk("loss_level", curLevel, lvl);
                    free_val = adv(lseed, i);
                    free_c   = cs + 1;
                    return;
                end
            end
            if (lvl == MAXL) begin
                nclk(1);
                chk("win_set", win, 1);
                free_val = v;
                free_c   = cs + 2;
                return;
            end
            q.push_back('{EV_S, lvl + 1});
            nclk(1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        int          wl;
        int          wi;
        nclk(1);
        do_reset();
        nclk(3);
        play(0, 0, 0, 0);
        nclk($urandom_range(0, 5));
        play(1, 1, 1, 0);
        nclk(2);
        play(0, 0, 0, 1);
        for (int g = 0; g < 8; g++) begin
            nclk($urandom_range(0, 6));
            wl = $urandom_range(0, MAXL);
            wi = (wl > 0) ? $urandom_range(0, wl + BASE - 2) : 0;
            play(wl, wi, g[0], 0);
        end
        nclk(2);
        do_reset();
        nclk(2);
        v = adv(free_val, cyc - free_c);
        playBtn = 1;
        q.push_back('{EV_S, 1});
        nclk(1);
        playBtn = 0;
        doneCounting = 1;
        nclk(1);
        doneCounting = 0;
        q.push_back('{EV_Y, int'(v[1:0])});
        q.push_back('{EV_Y, int'(nxt(v) & 16'h3)});
        nclk(2);
        tick1();
        nclk(2);
        tick1();
        nclk(1);
        do_reset();
        nclk(6);
`ifdef SEQ_TIMEOUT_EN
        playBtn = 1;
        q.push_back('{EV_S, 1});
        nclk(1);
        playBtn = 0;
        q.push_back('{EV_E, int'({1'b0, 1'b1, 1'b1, 4'd1})});
        for (int k = 0; k < 10; k++) begin
            tick1();
            nclk(1);
        end
        chk("tmo_err", timeoutErr, 1);
        chk("tmo_gameOver", gameOver, 1);
        do_reset();
        nclk(2);
`endif
        nclk(5);
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
